// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit for the EX stage: radix-2 restoring divide and shift-add multiply.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single cycle (IDLE->DONE directly).
module ex_muldiv (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_fsm;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_b_zero;
  logic [31:0] r_b;
  logic [31:0] r_q;
  logic [31:0] r_rem;

  logic        w_accept;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_fast;
  logic        w_last;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [32:0] w_sum;
  logic [31:0] w_rem_nx;
  logic [31:0] w_q_nx;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo;
  logic [31:0] w_rmd;

  assign w_accept = (r_state == S_IDLE) & start & ~flush;
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & A[31];
  assign w_b_neg  = w_signed & B[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag  = w_b_neg ? (32'd0 - B) : B;
  assign w_last   = (r_state == S_CALC) & (r_cnt == 5'd31);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_ax;
  logic [63:0] w_bx;
  logic [63:0] w_fast_prod;
  // Sign-extended 64-bit product: the low 64 bits are the exact two's complement result.
  assign w_ax        = {{32{w_a_neg}}, A};
  assign w_bx        = {{32{w_b_neg}}, B};
  assign w_fast_prod = w_ax * w_bx;
  assign w_fast      = w_accept & ~op[1];
`else
  assign w_fast      = 1'b0;
`endif

  // r_q holds the dividend (divide) or the multiplier (multiply); r_b holds the other operand.
  assign w_rem_sh = {r_rem, r_q[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_sum    = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : 33'd0);

  // One radix-2 step of the selected operation
  always_comb begin
    w_rem_nx = r_rem;
    w_q_nx   = r_q;
    if (r_is_div) begin
      w_rem_nx = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
      w_q_nx   = {r_q[30:0], ~w_diff[32]};
    end else begin
      w_rem_nx = w_sum[32:1];
      w_q_nx   = {w_sum[0], r_q[31:1]};
    end
  end

  // Divide by zero yields all-ones quotient; the remainder path naturally returns A.
  assign w_prod   = {w_rem_nx, w_q_nx};
  assign w_prod_s = r_neg_q ? (64'd0 - w_prod) : w_prod;
  assign w_quo    = r_b_zero ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_q_nx) : w_q_nx);
  assign w_rmd    = r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_next_fsm = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_fsm = w_fast ? S_DONE : S_CALC;
        end else begin
          w_next_fsm = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == 5'd31) begin
          w_next_fsm = S_DONE;
        end else begin
          w_next_fsm = S_CALC;
        end
      end
      S_DONE:  w_next_fsm = S_IDLE;
      default: w_next_fsm = S_IDLE;
    endcase
    w_next = flush ? S_IDLE : w_next_fsm;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand capture and iterative datapath
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_b      <= 32'd0;
      r_q      <= 32'd0;
      r_rem    <= 32'd0;
    end else if (w_accept) begin
      r_cnt    <= 5'd0;
      r_is_div <= op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b_zero <= (B == 32'd0);
      r_b      <= op[1] ? w_b_mag : w_a_mag;
      r_q      <= op[1] ? w_a_mag : w_b_mag;
      r_rem    <= 32'd0;
    end else if (flush) begin
      r_cnt    <= 5'd0;
    end else if (r_state == S_CALC) begin
      r_cnt    <= r_cnt + 5'd1;
      r_rem    <= w_rem_nx;
      r_q      <= w_q_nx;
    end
  end

  // Result registers, written only on the transition into DONE
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (w_last & ~flush) begin
      hi <= r_is_div ? w_rmd : w_prod_s[63:32];
      lo <= r_is_div ? w_quo : w_prod_s[31:0];
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (w_fast) begin
      hi <= w_fast_prod[63:32];
      lo <= w_fast_prod[31:0];
    end
`endif
  end

  assign stall = w_accept | (r_state == S_CALC);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases, randomized operations against an
// arithmetic reference model, flush and mid-operation reset scenarios.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  ex_muldiv dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like MIPS.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o == 2'b00) begin
      q = sa * sb;
      return q;
    end else if (o == 2'b01) begin
      return ua * ub;
    end else if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else if (o == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  // Issue one operation in the IDLE cycle following the current negedge and follow it to done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    logic [63:0] res;
    int lat;
    res = model(o, a, b);
    lat = o[1] ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_hi", hi, exp_hi);
    chk("idle_lo", lo, exp_lo);
    op = o; A = a; B = b; start = 1'b1;
    #1;
    chk("accept_stall", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        chk("calc_stall", {31'd0, stall}, 32'd1);
        chk("calc_done", {31'd0, done}, 32'd0);
        chk("calc_hi", hi, exp_hi);
        if (scramble) begin
          A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
        end
      end else begin
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk($sformatf("hi op%0d a=%h b=%h", o, a, b), hi, res[63:32]);
        chk($sformatf("lo op%0d a=%h b=%h", o, a, b), lo, res[31:0]);
        start = 1'b0;
      end
    end
    exp_hi = res[63:32];
    exp_lo = res[31:0];
  endtask

  initial begin
    bit seen_done;
    logic [31:0] ra, rb;
    resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);

    do_op(2'b11, 32'd100, 32'd7, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);

    repeat (30) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do_op(2'($urandom_range(0, 3)), ra, rb, 1'b1);
    end

    // Preload hi=0x11, lo=0x22, then flush a divide in its 10th cycle
    do_op(2'b11, 32'h451, 32'h20, 1'b0);
    @(negedge clk);
    op = 2'b11; A = $urandom; B = $urandom | 32'd1; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
    end
    chk("flush_c10_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush_c11_stall", {31'd0, stall}, 32'd0);
    flush = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("flush_no_done", {31'd0, seen_done}, 32'd0);
    chk("flush_hi", hi, 32'h11);
    chk("flush_lo", lo, 32'h22);

    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    op = 2'b10; A = 32'd99; B = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    chk("sf_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("sf_next_stall", {31'd0, stall}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("sf_no_done", {31'd0, seen_done}, 32'd0);
    chk("sf_hi", hi, 32'h11);
    chk("sf_lo", lo, 32'h22);

    // Reset in cycle 5 of a DIV
    @(negedge clk);
    op = 2'b10; A = 32'd1000; B = 32'd3; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
    end
    resetn = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    resetn = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    do_op(2'b10, 32'hFFFF_FC18, 32'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
